// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch sequencer bus bundle: execute redirect, instruction memory, decode handoff
interface pc_fetch_ctrl_if #(
    parameter int DWIDTH = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [DWIDTH-1:0] redirect_pc;
    logic              imem_req;
    logic [DWIDTH-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [DWIDTH-1:0] instr_pc;
    logic              misalign_err;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - rv32i fetch sequencer: PC register, single-outstanding imem fetch, redirect handling
module pc_fetch_ctrl #(
    parameter int                 DWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_fetch_ctrl_if.master       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] pc_next;
    logic [31:0]       instr_q;
    logic [DWIDTH-1:0] instr_pc_q;
    logic              capture;
    logic              redirect_take;
    logic              redirect_aligned;

    assign redirect_take    = bus.redirect_valid && (state != ERR);
    assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect overrides whatever the state would have done, including
    // discarding a word acked in the same cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (bus.imem_ack) begin
                    capture    = 1'b1;
                    pc_next    = pc + DWIDTH'(4);
                    state_next = OUT;
                end
            end
            OUT: begin
                if (!bus.stall) begin
                    state_next = REQ;
                end
            end
            ERR: state_next = ERR;
            default: state_next = IDLE;
        endcase
        if (redirect_take) begin
            capture    = 1'b0;
            pc_next    = bus.redirect_pc;
            state_next = redirect_aligned ? REQ : ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            pc <= pc_next;
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // combinationally.
    assign bus.imem_req     = (state == REQ);
    assign bus.imem_addr    = pc;
    assign bus.instr_valid  = (state == OUT);
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.misalign_err = (state == ERR);
endmodule
